// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
// Checker for one PWM generator output. Measures the period and high time of
// every PWM cycle and reports the duty as an integer percentage, and flags an
// input that stops toggling.
//
// Ports:
//   clk_in   system clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   pwm_in   PWM signal under test (asynchronous to clk_in)
//   duty     measured duty in percent, 0..100
//   period   measured period in clk_in cycles
//   valid    one-cycle pulse when duty/period update
//   stuck    set by a no-edge timeout, cleared by the next divided result
//   dropped  one-cycle pulse when a finished period is discarded (divider busy)
//
// Build option: define PWM_METER_ROUND_EN to round the duty to the nearest
// percent instead of truncating. Latency is the same either way.
//
// state       | meaning
// ST_WAIT     | counters cleared, waiting for the first rising edge
// ST_MEASURE  | counting; each later rising edge closes a period
// DIV_IDLE    | divider free to take a snapshot
// DIV_RUN     | restoring division, one quotient bit per cycle

module pwm_duty_meter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [6:0]       duty,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stuck,
   output logic             dropped
);

   localparam int NUM_W  = CNT_W + 7;
   localparam int ITER_W = $clog2(NUM_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {ST_WAIT, ST_MEASURE} meas_state_t;
   typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

   meas_state_t state, state_nxt;
   div_state_t  div_state, div_state_nxt;

   logic pwm_s1, pwm_sync, pwm_prev, rise;
   logic [CNT_W-1:0] tot_cnt, hi_cnt;
   logic timeout, accept, drop, div_done;

   logic [NUM_W-1:0]  numer, num_q, q_nxt;
   logic [CNT_W-1:0]  den_q, rem_q, rem_nxt;
   logic [CNT_W:0]    trial, diff;
   logic              q_bit;
   logic [ITER_W-1:0] iter_q;

   // The synchronizer is deliberately not reset so that pwm_prev always
   // tracks the real input; resetting it would fake a rising edge when
   // pwm_in happens to be high as reset is released.
   always_ff @(posedge clk_in) begin
      pwm_s1   <= pwm_in;
      pwm_sync <= pwm_s1;
      pwm_prev <= pwm_sync;
   end

   assign rise = pwm_sync & ~pwm_prev;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= ST_WAIT;
         div_state <= DIV_IDLE;
      end else begin
         state     <= state_nxt;
         div_state <= div_state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timeout   = 1'b0;
      accept    = 1'b0;
      drop      = 1'b0;
      case (state)
         ST_WAIT: begin
            if (rise) state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            // Timeout has priority over an edge in the same cycle.
            if (tot_cnt == CNT_MAX) begin
               timeout   = 1'b1;
               state_nxt = ST_WAIT;
            end else if (rise) begin
               if (div_state == DIV_IDLE) accept = 1'b1;
               else                       drop   = 1'b1;
            end
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      div_state_nxt = div_state;
      div_done      = 1'b0;
      case (div_state)
         DIV_IDLE: begin
            if (accept) div_state_nxt = DIV_RUN;
         end
         DIV_RUN: begin
            if (timeout) begin
               div_state_nxt = DIV_IDLE;
            end else if (iter_q == ITER_W'(1)) begin
               div_done      = 1'b1;
               div_state_nxt = DIV_IDLE;
            end
         end
         default: div_state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst || timeout) begin
         tot_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         tot_cnt <= CNT_W'(1);
         hi_cnt  <= CNT_W'(pwm_sync);
      end else if (state == ST_MEASURE) begin
         tot_cnt <= tot_cnt + CNT_W'(1);
         hi_cnt  <= hi_cnt + CNT_W'(pwm_sync);
      end
   end

   always_comb begin
      numer = NUM_W'(hi_cnt) * NUM_W'(100);
`ifdef PWM_METER_ROUND_EN
      numer = numer + NUM_W'(tot_cnt >> 1);
`endif
   end

   // Partial remainder is always below the divisor, so the shifted trial fits
   // in CNT_W+1 bits and the top bit of the difference is the borrow.
   assign trial   = {rem_q, num_q[NUM_W-1]};
   assign diff    = trial - {1'b0, den_q};
   assign q_bit   = ~diff[CNT_W];
   assign rem_nxt = q_bit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
   assign q_nxt   = {num_q[NUM_W-2:0], q_bit};

   always_ff @(posedge clk_in) begin
      if (rst) begin
         num_q  <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         iter_q <= '0;
      end else if (accept) begin
         num_q  <= numer;
         den_q  <= tot_cnt;
         rem_q  <= '0;
         iter_q <= ITER_W'(NUM_W);
      end else if (div_state == DIV_RUN) begin
         num_q  <= q_nxt;
         rem_q  <= rem_nxt;
         iter_q <= iter_q - ITER_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         duty    <= '0;
         period  <= '0;
         valid   <= 1'b0;
         stuck   <= 1'b0;
         dropped <= 1'b0;
      end else begin
         valid   <= 1'b0;
         dropped <= drop;
         if (timeout) begin
            duty   <= pwm_sync ? 7'd100 : 7'd0;
            period <= CNT_MAX;
            valid  <= 1'b1;
            stuck  <= 1'b1;
         end else if (div_done) begin
            duty   <= (q_nxt > NUM_W'(100)) ? 7'd100 : q_nxt[6:0];
            period <= den_q;
            valid  <= 1'b1;
            stuck  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter. A narrower counter width than the default
// keeps the no-edge timeout scenarios short.
module tb_pwm_duty_meter;

   localparam int CNT_W = 13;
   localparam int MAXV  = (1 << CNT_W) - 1;
   // Cycles from driving a rising pwm_in edge to the resulting valid.
   localparam int LAT   = CNT_W + 10;
   // Minimum spacing of driven edges for the divider to accept both.
   localparam int BUSY  = CNT_W + 8;

   logic             clk_in = 1'b0;
   logic             rst    = 1'b1;
   logic             pwm_in = 1'b0;
   logic [6:0]       duty;
   logic [CNT_W-1:0] period;
   logic             valid, stuck, dropped;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int   t;
      int   duty;
      int   period;
      logic stuck;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  exp_drop[$];
   int  obs_drop[$];

   // Reference model state: edge times as driven by the bench.
   bit m_wait  = 1'b1;
   bit m_level = 1'b0;
   int m_last  = 0;
   int m_fall  = 0;
   int m_free  = 0;

   pwm_duty_meter #(.CNT_W(CNT_W)) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .pwm_in  (pwm_in),
      .duty    (duty),
      .period  (period),
      .valid   (valid),
      .stuck   (stuck),
      .dropped (dropped)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (valid)   obs_q.push_back('{cyc, int'(duty), int'(period), stuck});
      if (dropped) obs_drop.push_back(cyc);
   end

   function automatic int ref_duty(input int h, input int p);
      int q;
`ifdef PWM_METER_ROUND_EN
      q = (h * 100 + p / 2) / p;
`else
      q = (h * 100) / p;
`endif
      return (q > 100) ? 100 : q;
   endfunction

   // Event-level model: a period is closed by each rising edge; its result
   // appears LAT cycles after that edge if the divider was free, otherwise it
   // is dropped. No edge for MAXV cycles reports the held level as 0/100%.
   function automatic void model_step(input int t, input bit lvl);
      bit rose;
      rose = lvl && !m_level;
      if (!lvl && m_level) m_fall = t;
      m_level = lvl;
      if (!m_wait && (t - m_last) >= MAXV) begin
         for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].t >= m_last + MAXV + 3) exp_q.delete(i);
         exp_q.push_back('{m_last + MAXV + 3, lvl ? 100 : 0, MAXV, 1'b1});
         m_wait = 1'b1;
         m_free = 0;
         return;
      end
      if (rose) begin
         if (m_wait) begin
            m_wait = 1'b0;
         end else if (t >= m_free) begin
            exp_q.push_back('{t + LAT, ref_duty(m_fall - m_last, t - m_last), t - m_last, 1'b0});
            m_free = t + BUSY;
         end else begin
            exp_drop.push_back(t + 3);
         end
         m_last = t;
      end
   endfunction

   task automatic drive(input logic lvl, input int n);
      repeat (n) begin
         @(negedge clk_in);
         pwm_in = lvl;
         model_step(cyc, lvl);
      end
   endtask

   task automatic pulses(input int p, input int h, input int n);
      repeat (n) begin
         drive(1'b1, h);
         drive(1'b0, p - h);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (4) @(negedge clk_in);
      rst = 1'b0;
      m_wait = 1'b1; m_level = 1'b0; m_free = 0;
      exp_q.delete(); obs_q.delete(); exp_drop.delete(); obs_drop.delete();
   endtask

   task automatic test_reset();
      do_reset();
      vectors += 5;
      if (duty !== 7'd0)   begin miscompares++; $display("FAIL reset_duty: got %0d, expected 0", duty); end
      if (period !== '0)   begin miscompares++; $display("FAIL reset_period: got %0d, expected 0", period); end
      if (valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid: got %0b, expected 0", valid); end
      if (stuck !== 1'b0)  begin miscompares++; $display("FAIL reset_stuck: got %0b, expected 0", stuck); end
      if (dropped !== 1'b0) begin miscompares++; $display("FAIL reset_dropped: got %0b, expected 0", dropped); end
      drive(1'b0, 300);
      vectors++;
      if (obs_q.size() != 0 || obs_drop.size() != 0) begin
         miscompares++;
         $display("FAIL reset_idle: got %0d valid / %0d dropped pulses, expected none", obs_q.size(), obs_drop.size());
      end
   endtask

   task automatic test_basic();
      ev_t o;
      do_reset();
      drive(1'b0, 3);
      pulses(100, 30, 4);
      pulses(3, 2, 22);
      pulses(3, 1, 22);
      drive(1'b0, LAT + 4);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL basic_valid: missing result, expected cyc %0d duty %0d period %0d", exp_q[i].t, exp_q[i].duty, exp_q[i].period);
         end else begin
            o = obs_q.pop_front();
            if (o.t != exp_q[i].t || o.duty != exp_q[i].duty || o.period != exp_q[i].period || o.stuck !== exp_q[i].stuck) begin
               miscompares++;
               $display("FAIL basic_valid: got cyc %0d duty %0d period %0d stuck %0b, expected cyc %0d duty %0d period %0d stuck %0b",
                        o.t, o.duty, o.period, o.stuck, exp_q[i].t, exp_q[i].duty, exp_q[i].period, exp_q[i].stuck);
            end
         end
      end
      vectors++;
      if (obs_q.size() != 0 || obs_drop.size() != exp_drop.size()) begin
         miscompares++;
         $display("FAIL basic_counts: got %0d extra valid, %0d dropped, expected 0 extra, %0d dropped", obs_q.size(), obs_drop.size(), exp_drop.size());
      end else begin
         foreach (exp_drop[i]) begin
            vectors++;
            if (obs_drop[i] != exp_drop[i]) begin
               miscompares++;
               $display("FAIL basic_dropped: got cyc %0d, expected cyc %0d", obs_drop[i], exp_drop[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      ev_t o;
      do_reset();
      pulses(10, 5, 40);
      drive(1'b0, LAT + 4);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_valid: missing result, expected cyc %0d duty %0d period %0d", exp_q[i].t, exp_q[i].duty, exp_q[i].period);
         end else begin
            o = obs_q.pop_front();
            if (o.t != exp_q[i].t || o.duty != exp_q[i].duty || o.period != exp_q[i].period || o.stuck !== exp_q[i].stuck) begin
               miscompares++;
               $display("FAIL b2b_valid: got cyc %0d duty %0d period %0d stuck %0b, expected cyc %0d duty %0d period %0d stuck %0b",
                        o.t, o.duty, o.period, o.stuck, exp_q[i].t, exp_q[i].duty, exp_q[i].period, exp_q[i].stuck);
            end
         end
      end
      vectors++;
      if (obs_q.size() != 0 || obs_drop.size() != exp_drop.size()) begin
         miscompares++;
         $display("FAIL b2b_counts: got %0d extra valid, %0d dropped, expected 0 extra, %0d dropped", obs_q.size(), obs_drop.size(), exp_drop.size());
      end else begin
         foreach (exp_drop[i]) begin
            vectors++;
            if (obs_drop[i] != exp_drop[i]) begin
               miscompares++;
               $display("FAIL b2b_dropped: got cyc %0d, expected cyc %0d", obs_drop[i], exp_drop[i]);
            end
         end
      end
   endtask

   task automatic test_stuck();
      ev_t o;
      do_reset();
      drive(1'b0, 5);
      drive(1'b1, MAXV + 20);
      vectors++;
      if (stuck !== 1'b1) begin miscompares++; $display("FAIL stuck_set: got %0b, expected 1", stuck); end
      drive(1'b0, 60);
      pulses(200, 140, 2);
      vectors++;
      if (stuck !== 1'b0) begin miscompares++; $display("FAIL stuck_clear: got %0b, expected 0", stuck); end
      pulses(200, 140, 1);
      drive(1'b0, MAXV + 20);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL stuck_valid: missing result, expected cyc %0d duty %0d period %0d", exp_q[i].t, exp_q[i].duty, exp_q[i].period);
         end else begin
            o = obs_q.pop_front();
            if (o.t != exp_q[i].t || o.duty != exp_q[i].duty || o.period != exp_q[i].period || o.stuck !== exp_q[i].stuck) begin
               miscompares++;
               $display("FAIL stuck_valid: got cyc %0d duty %0d period %0d stuck %0b, expected cyc %0d duty %0d period %0d stuck %0b",
                        o.t, o.duty, o.period, o.stuck, exp_q[i].t, exp_q[i].duty, exp_q[i].period, exp_q[i].stuck);
            end
         end
      end
      vectors++;
      if (obs_q.size() != 0 || obs_drop.size() != exp_drop.size()) begin
         miscompares++;
         $display("FAIL stuck_counts: got %0d extra valid, %0d dropped, expected 0 extra, %0d dropped", obs_q.size(), obs_drop.size(), exp_drop.size());
      end
   endtask

   task automatic test_reset_mid();
      ev_t o;
      do_reset();
      pulses(100, 5, 2);
      drive(1'b1, 5);
      drive(1'b0, 8);
      @(negedge clk_in);
      rst = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].t > cyc) void'(exp_q.pop_back());
      @(negedge clk_in);
      vectors += 5;
      if (duty !== 7'd0)    begin miscompares++; $display("FAIL midrst_duty: got %0d, expected 0", duty); end
      if (period !== '0)    begin miscompares++; $display("FAIL midrst_period: got %0d, expected 0", period); end
      if (valid !== 1'b0)   begin miscompares++; $display("FAIL midrst_valid: got %0b, expected 0", valid); end
      if (stuck !== 1'b0)   begin miscompares++; $display("FAIL midrst_stuck: got %0b, expected 0", stuck); end
      if (dropped !== 1'b0) begin miscompares++; $display("FAIL midrst_dropped: got %0b, expected 0", dropped); end
      rst = 1'b0;
      m_wait = 1'b1; m_free = 0;
      drive(1'b0, 40);
      pulses(100, 30, 3);
      drive(1'b0, LAT + 4);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL midrst_result: missing result, expected cyc %0d duty %0d period %0d", exp_q[i].t, exp_q[i].duty, exp_q[i].period);
         end else begin
            o = obs_q.pop_front();
            if (o.t != exp_q[i].t || o.duty != exp_q[i].duty || o.period != exp_q[i].period || o.stuck !== exp_q[i].stuck) begin
               miscompares++;
               $display("FAIL midrst_result: got cyc %0d duty %0d period %0d stuck %0b, expected cyc %0d duty %0d period %0d stuck %0b",
                        o.t, o.duty, o.period, o.stuck, exp_q[i].t, exp_q[i].duty, exp_q[i].period, exp_q[i].stuck);
            end
         end
      end
      vectors++;
      if (obs_q.size() != 0 || obs_drop.size() != exp_drop.size()) begin
         miscompares++;
         $display("FAIL midrst_counts: got %0d extra valid, %0d dropped, expected 0 extra, %0d dropped", obs_q.size(), obs_drop.size(), exp_drop.size());
      end
   endtask

   task automatic test_random();
      ev_t o;
      int  p, h;
      do_reset();
      repeat (30) begin
         p = $urandom_range(60, 2);
         h = $urandom_range(p - 1, 1);
         pulses(p, h, $urandom_range(4, 1));
         drive(1'b0, $urandom_range(30, 0));
      end
      drive(1'b0, LAT + 4);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL rand_valid: missing result, expected cyc %0d duty %0d period %0d", exp_q[i].t, exp_q[i].duty, exp_q[i].period);
         end else begin
            o = obs_q.pop_front();
            if (o.t != exp_q[i].t || o.duty != exp_q[i].duty || o.period != exp_q[i].period || o.stuck !== exp_q[i].stuck) begin
               miscompares++;
               $display("FAIL rand_valid: got cyc %0d duty %0d period %0d stuck %0b, expected cyc %0d duty %0d period %0d stuck %0b",
                        o.t, o.duty, o.period, o.stuck, exp_q[i].t, exp_q[i].duty, exp_q[i].period, exp_q[i].stuck);
            end
         end
      end
      vectors++;
      if (obs_q.size() != 0 || obs_drop.size() != exp_drop.size()) begin
         miscompares++;
         $display("FAIL rand_counts: got %0d extra valid, %0d dropped, expected 0 extra, %0d dropped", obs_q.size(), obs_drop.size(), exp_drop.size());
      end else begin
         foreach (exp_drop[i]) begin
            vectors++;
            if (obs_drop[i] != exp_drop[i]) begin
               miscompares++;
               $display("FAIL rand_dropped: got cyc %0d, expected cyc %0d", obs_drop[i], exp_drop[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stuck();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
